// File: rtl/getir_birimi.sv
// getir_birimi: instruction fetch stage feeding the gshare predictor and decode.
//
// Owns the program counter and keeps at most one instruction-memory request in flight.
// The fetched word is presented together with its PC; the next PC comes from the
// predictor's same-cycle decision. An execute-stage redirect overrides everything, and
// any response that belongs to a redirected request is discarded.
//
// Optional feature macro: GETIR_SAYAC_EN (adds sayac_getir / sayac_duzelt counters).
//
// Ports:
//   clk, rst                    clock; synchronous active-low reset
//   bellek_istek_gecerli/adres  memory request valid / word-aligned address
//   bellek_istek_hazir          memory accepts the request this cycle
//   bellek_yanit_gecerli/buyruk memory response valid / instruction word
//   getir_ps/buyruk/gecerli     presented instruction (zero when not presenting)
//   sonuc_dallan/_ps            predictor taken decision and target for getir_ps
//   getir_tahmin                registered predictor decision travelling to decode
//   coz_hazir                   decode accepts the presented instruction
//   duzelt_gecerli/_ps          mispredict redirect and its target
//   sayac_getir/sayac_duzelt    handshake and redirect counters (GETIR_SAYAC_EN only)

module getir_birimi #(
    parameter logic [31:0] RESET_PS = 32'h0000_0000,
    parameter int unsigned SAYAC_W  = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        bellek_istek_gecerli,
    output logic [31:0] bellek_istek_adres,
    input  logic        bellek_istek_hazir,
    input  logic        bellek_yanit_gecerli,
    input  logic [31:0] bellek_yanit_buyruk,
    output logic [31:0] getir_ps,
    output logic [31:0] getir_buyruk,
    output logic        getir_gecerli,
    input  logic        sonuc_dallan,
    input  logic [31:0] sonuc_dallan_ps,
    output logic        getir_tahmin,
    input  logic        coz_hazir,
    input  logic        duzelt_gecerli,
    input  logic [31:0] duzelt_ps
`ifdef GETIR_SAYAC_EN
    ,
    output logic [SAYAC_W-1:0] sayac_getir,
    output logic [SAYAC_W-1:0] sayac_duzelt
`endif
);

    typedef enum logic [1:0] {
        StIste,
        StBekle,
        StSun,
        StIptal
    } durum_e;

    durum_e      durum_q, durum_d;
    logic [31:0] ps_q, ps_d;
    logic [31:0] buyruk_q, buyruk_d;
    logic        tahmin_q, tahmin_d;

    // Low address bits of targets are forced to zero, so the incoming bits [1:0] are unused.
    logic unused_hizasiz;
    assign unused_hizasiz = ^{sonuc_dallan_ps[1:0], duzelt_ps[1:0]};

    logic [31:0] duzelt_hizali;
    logic [31:0] dallan_hizali;
    assign duzelt_hizali = {duzelt_ps[31:2], 2'b00};
    assign dallan_hizali = {sonuc_dallan_ps[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst) begin
            durum_q  <= StIste;
            ps_q     <= RESET_PS;
            buyruk_q <= 32'h0;
            tahmin_q <= 1'b0;
        end else begin
            durum_q  <= durum_d;
            ps_q     <= ps_d;
            buyruk_q <= buyruk_d;
            tahmin_q <= tahmin_d;
        end
    end

    always_comb begin
        durum_d  = durum_q;
        ps_d     = ps_q;
        buyruk_d = buyruk_q;
        tahmin_d = tahmin_q;

        unique case (durum_q)
            StIste: begin
                if (duzelt_gecerli) begin
                    ps_d = duzelt_hizali;
                    // An accepted request now belongs to the old PC; its response must be eaten.
                    durum_d = bellek_istek_hazir ? StIptal : StIste;
                end else if (bellek_istek_hazir) begin
                    durum_d = StBekle;
                end
            end
            StBekle: begin
                if (duzelt_gecerli) begin
                    ps_d    = duzelt_hizali;
                    durum_d = bellek_yanit_gecerli ? StIste : StIptal;
                end else if (bellek_yanit_gecerli) begin
                    buyruk_d = bellek_yanit_buyruk;
                    durum_d  = StSun;
                end
            end
            StSun: begin
                if (duzelt_gecerli) begin
                    ps_d    = duzelt_hizali;
                    durum_d = StIste;
                end else if (coz_hazir) begin
                    ps_d     = sonuc_dallan ? dallan_hizali : ps_q + 32'd4;
                    tahmin_d = sonuc_dallan;
                    durum_d  = StIste;
                end
            end
            StIptal: begin
                if (duzelt_gecerli) begin
                    ps_d = duzelt_hizali;
                end
                // A response arriving alongside a redirect is still the stale one.
                if (bellek_yanit_gecerli) begin
                    durum_d = StIste;
                end
            end
            default: begin
                durum_d = StIste;
            end
        endcase
    end

    // Outputs are gated by rst so nothing is issued or presented in the reset cycle.
    always_comb begin
        bellek_istek_gecerli = rst && (durum_q == StIste);
        bellek_istek_adres   = ps_q;
        getir_gecerli        = rst && (durum_q == StSun);
        getir_ps             = getir_gecerli ? ps_q : 32'h0;
        getir_buyruk         = getir_gecerli ? buyruk_q : 32'h0;
        getir_tahmin         = tahmin_q;
    end

`ifdef GETIR_SAYAC_EN
    logic [SAYAC_W-1:0] sayac_getir_q, sayac_getir_d;
    logic [SAYAC_W-1:0] sayac_duzelt_q, sayac_duzelt_d;

    always_comb begin
        sayac_getir_d  = sayac_getir_q;
        sayac_duzelt_d = sayac_duzelt_q;
        if (getir_gecerli && coz_hazir && !duzelt_gecerli) begin
            sayac_getir_d = sayac_getir_q + 1'b1;
        end
        if (duzelt_gecerli) begin
            sayac_duzelt_d = sayac_duzelt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sayac_getir_q  <= '0;
            sayac_duzelt_q <= '0;
        end else begin
            sayac_getir_q  <= sayac_getir_d;
            sayac_duzelt_q <= sayac_duzelt_d;
        end
    end

    assign sayac_getir  = sayac_getir_q;
    assign sayac_duzelt = sayac_duzelt_q;
`else
    localparam int unsigned unused_sayac_w = SAYAC_W;
`endif

endmodule

// File: tb/tb_getir_birimi.sv
module tb_getir_birimi;

    logic        clk = 1'b0;
    logic        rst;
    logic        bellek_istek_gecerli;
    logic [31:0] bellek_istek_adres;
    logic        bellek_istek_hazir;
    logic        bellek_yanit_gecerli;
    logic [31:0] bellek_yanit_buyruk;
    logic [31:0] getir_ps;
    logic [31:0] getir_buyruk;
    logic        getir_gecerli;
    logic        sonuc_dallan;
    logic [31:0] sonuc_dallan_ps;
    logic        getir_tahmin;
    logic        coz_hazir;
    logic        duzelt_gecerli;
    logic [31:0] duzelt_ps;
`ifdef GETIR_SAYAC_EN
    logic [31:0] sayac_getir;
    logic [31:0] sayac_duzelt;
`endif

    getir_birimi #(
        .RESET_PS(32'h0000_0000),
        .SAYAC_W (32)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .bellek_istek_gecerli(bellek_istek_gecerli),
        .bellek_istek_adres  (bellek_istek_adres),
        .bellek_istek_hazir  (bellek_istek_hazir),
        .bellek_yanit_gecerli(bellek_yanit_gecerli),
        .bellek_yanit_buyruk (bellek_yanit_buyruk),
        .getir_ps            (getir_ps),
        .getir_buyruk        (getir_buyruk),
        .getir_gecerli       (getir_gecerli),
        .sonuc_dallan        (sonuc_dallan),
        .sonuc_dallan_ps     (sonuc_dallan_ps),
        .getir_tahmin        (getir_tahmin),
        .coz_hazir           (coz_hazir),
        .duzelt_gecerli      (duzelt_gecerli),
        .duzelt_ps           (duzelt_ps)
`ifdef GETIR_SAYAC_EN
        ,
        .sayac_getir         (sayac_getir),
        .sayac_duzelt        (sayac_duzelt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];  // {ps, instruction} expected at each decode handshake

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: every accepted presentation must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && getir_gecerli === 1'b1 && coz_hazir === 1'b1
            && duzelt_gecerli === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_ps", getir_ps, 32'hxxxx_xxxx);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("sb_ps", getir_ps, e[63:32]);
                chk("sb_buyruk", getir_buyruk, e[31:0]);
            end
        end
    end

    // Issue at pc, return word one cycle later; leaves the DUT presenting.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] word, input bit push);
        bellek_istek_hazir = 1'b1;
        #1;
        chk("fetch_adres", bellek_istek_adres, pc);
        chk("fetch_istek", {31'h0, bellek_istek_gecerli}, 32'h1);
        tick();
        bellek_istek_hazir   = 1'b0;
        bellek_yanit_gecerli = 1'b1;
        bellek_yanit_buyruk  = word;
        if (push) exp_q.push_back({pc, word});
        tick();
        bellek_yanit_gecerli = 1'b0;
        #1;
        chk("fetch_sun", {31'h0, getir_gecerli}, 32'h1);
    endtask

    initial begin
        rst = 1'b0;
        bellek_istek_hazir = 1'b0;
        bellek_yanit_gecerli = 1'b0;
        bellek_yanit_buyruk = 32'h0;
        sonuc_dallan = 1'b0;
        sonuc_dallan_ps = 32'h0;
        coz_hazir = 1'b0;
        duzelt_gecerli = 1'b0;
        duzelt_ps = 32'h0;

        // Reset
        tick();
        tick();
        #1;
        chk("rst_istek", {31'h0, bellek_istek_gecerli}, 32'h0);
        chk("rst_gecerli", {31'h0, getir_gecerli}, 32'h0);
        chk("rst_ps", getir_ps, 32'h0);
        chk("rst_tahmin", {31'h0, getir_tahmin}, 32'h0);
        rst = 1'b1;
        #1;
        chk("post_rst_adres", bellek_istek_adres, 32'h0);
        chk("post_rst_istek", {31'h0, bellek_istek_gecerli}, 32'h1);
        chk("post_rst_gecerli", {31'h0, getir_gecerli}, 32'h0);

        // Sequential fetch
        fetch(32'h0, 32'h1234, 1'b1);
        chk("seq_ps", getir_ps, 32'h0);
        chk("seq_buyruk", getir_buyruk, 32'h1234);
        coz_hazir = 1'b1;
        tick();
        coz_hazir = 1'b0;
        #1;
        chk("seq_next_adres", bellek_istek_adres, 32'h4);
        chk("seq_tahmin", {31'h0, getir_tahmin}, 32'h0);

        // Predicted taken from 0x100 (redirect in ISTE without accept to get there)
        duzelt_gecerli = 1'b1;
        duzelt_ps = 32'h100;
        tick();
        duzelt_gecerli = 1'b0;
        fetch(32'h100, 32'h1111_0001, 1'b1);
        sonuc_dallan = 1'b1;
        sonuc_dallan_ps = 32'h203;
        coz_hazir = 1'b1;
        tick();
        sonuc_dallan = 1'b0;
        coz_hazir = 1'b0;
        #1;
        chk("taken_adres", bellek_istek_adres, 32'h200);
        chk("taken_tahmin", {31'h0, getir_tahmin}, 32'h1);

        // Redirect while BEKLE at 0x300; stale 0xDEAD must never be presented
        duzelt_gecerli = 1'b1;
        duzelt_ps = 32'h300;
        tick();
        duzelt_gecerli = 1'b0;
        bellek_istek_hazir = 1'b1;
        tick();
        bellek_istek_hazir = 1'b0;
        duzelt_gecerli = 1'b1;
        duzelt_ps = 32'h400;
        tick();
        duzelt_gecerli = 1'b0;
        #1;
        chk("iptal_istek", {31'h0, bellek_istek_gecerli}, 32'h0);
        bellek_yanit_gecerli = 1'b1;
        bellek_yanit_buyruk = 32'hDEAD;
        tick();
        bellek_yanit_gecerli = 1'b0;
        #1;
        chk("bekle_redir_gecerli", {31'h0, getir_gecerli}, 32'h0);
        chk("bekle_redir_adres", bellek_istek_adres, 32'h400);

        // Redirect in ISTE on the accept cycle goes through IPTAL
        bellek_istek_hazir = 1'b1;
        duzelt_gecerli = 1'b1;
        duzelt_ps = 32'h502;
        tick();
        bellek_istek_hazir = 1'b0;
        duzelt_gecerli = 1'b0;
        #1;
        chk("iste_redir_istek", {31'h0, bellek_istek_gecerli}, 32'h0);
        bellek_yanit_gecerli = 1'b1;
        bellek_yanit_buyruk = 32'hBEEF;
        tick();
        bellek_yanit_gecerli = 1'b0;
        #1;
        chk("iste_redir_adres", bellek_istek_adres, 32'h500);
        chk("iste_redir_gecerli", {31'h0, getir_gecerli}, 32'h0);

        // Redirect in SUN with coz_hazir: drop instruction, ignore predictor
        fetch(32'h500, 32'hAAAA, 1'b0);
        coz_hazir = 1'b1;
        sonuc_dallan = 1'b1;
        sonuc_dallan_ps = 32'h700;
        duzelt_gecerli = 1'b1;
        duzelt_ps = 32'h600;
        tick();
        coz_hazir = 1'b0;
        sonuc_dallan = 1'b0;
        duzelt_gecerli = 1'b0;
        #1;
        chk("sun_redir_adres", bellek_istek_adres, 32'h600);
        chk("sun_redir_gecerli", {31'h0, getir_gecerli}, 32'h0);
        chk("sun_redir_tahmin", {31'h0, getir_tahmin}, 32'h1);
`ifdef GETIR_SAYAC_EN
        chk("sayac_duzelt", sayac_duzelt, 32'd5);
        chk("sayac_getir", sayac_getir, 32'd2);
`endif

        // Wrap and stall at 0xFFFF_FFFC; a response during SUN must not disturb the word
        duzelt_gecerli = 1'b1;
        duzelt_ps = 32'hFFFF_FFFC;
        tick();
        duzelt_gecerli = 1'b0;
        fetch(32'hFFFF_FFFC, 32'h5555, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bellek_yanit_gecerli = (i == 1);
            bellek_yanit_buyruk = 32'hBAD0;
            tick();
            #1;
            chk("stall_gecerli", {31'h0, getir_gecerli}, 32'h1);
            chk("stall_ps", getir_ps, 32'hFFFF_FFFC);
            chk("stall_buyruk", getir_buyruk, 32'h5555);
            chk("stall_istek", {31'h0, bellek_istek_gecerli}, 32'h0);
        end
        bellek_yanit_gecerli = 1'b0;
        coz_hazir = 1'b1;
        tick();
        coz_hazir = 1'b0;
        #1;
        chk("wrap_adres", bellek_istek_adres, 32'h0);
        chk("wrap_tahmin", {31'h0, getir_tahmin}, 32'h0);

        // Reset mid-transaction, then a late response in ISTE is ignored
        duzelt_gecerli = 1'b1;
        duzelt_ps = 32'h800;
        tick();
        duzelt_gecerli = 1'b0;
        bellek_istek_hazir = 1'b1;
        tick();
        bellek_istek_hazir = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_istek", {31'h0, bellek_istek_gecerli}, 32'h0);
        tick();
        rst = 1'b1;
        bellek_yanit_gecerli = 1'b1;
        bellek_yanit_buyruk = 32'hBAD1;
        tick();
        bellek_yanit_gecerli = 1'b0;
        #1;
        chk("midrst_adres", bellek_istek_adres, 32'h0);
        chk("midrst_istek2", {31'h0, bellek_istek_gecerli}, 32'h1);
        chk("midrst_gecerli", {31'h0, getir_gecerli}, 32'h0);

        tick();
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
